// File: rtl/ahb_apb_bridge_if.sv
`default_nettype none
// ============================================================================
// ahb_apb_bridge_if : AHB-Lite slave side and APB3 master side of the bridge
// Rev 1.0
// ============================================================================
interface ahb_apb_bridge_if #(
   parameter int ADDR_WIDTH = 16
);
   // AHB-Lite
   logic                  HSEL;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [3:0]            HPROT;
   logic                  HREADY;
   logic [31:0]           HWDATA;
   logic                  HREADYOUT;
   logic                  HRESP;
   logic [31:0]           HRDATA;

   // APB3
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [ADDR_WIDTH-1:0] PADDR;
   logic [31:0]           PWDATA;
   logic [31:0]           PRDATA;
   logic                  PREADY;
   logic                  PSLVERR;

   // Bridge view: AHB slave, APB master
   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HREADY, HWDATA,
      output HREADYOUT, HRESP, HRDATA,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   // Environment view: AHB master, APB slave
   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HPROT, HREADY, HWDATA,
      input  HREADYOUT, HRESP, HRDATA,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface
`default_nettype wire

// File: rtl/ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
// ahb_apb_bridge : AHB-Lite slave to APB3 master, one 32-bit APB access per
//                  AHB NONSEQ/SEQ transfer, two-cycle AHB error on PSLVERR.
// Rev 1.0
// ============================================================================
module ahb_apb_bridge #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic            HCLK,
   input  logic            HRESET,
   ahb_apb_bridge_if.slave bus
);
   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_WDATA  = 3'd1;
   localparam logic [2:0] c_SETUP  = 3'd2;
   localparam logic [2:0] c_ACCESS = 3'd3;
   localparam logic [2:0] c_ERR1   = 3'd4;
   localparam logic [2:0] c_ERR2   = 3'd5;

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_pwrite;
   logic [31:0]           r_pwdata;
   logic [31:0]           r_hrdata;
   logic                  w_ready_state;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_unused;

   // ERR2 is the second error cycle but already HREADYOUT=1, so it accepts too
   assign w_ready_state = (r_state == c_IDLE) || (r_state == c_ERR2);
   assign w_accept      = w_ready_state && bus.HSEL && bus.HREADY && bus.HTRANS[1];
   assign w_done        = (r_state == c_ACCESS) && bus.PREADY;
   assign w_unused      = ^{bus.HSIZE, bus.HPROT, bus.HTRANS[0]};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE, c_ERR2: begin
            if (w_accept) begin
               w_state_nxt = bus.HWRITE ? c_WDATA : c_SETUP;
            end else begin
               w_state_nxt = c_IDLE;
            end
         end
         c_WDATA:  w_state_nxt = c_SETUP;
         c_SETUP:  w_state_nxt = c_ACCESS;
         c_ACCESS: begin
            if (bus.PREADY) begin
               w_state_nxt = bus.PSLVERR ? c_ERR1 : c_IDLE;
            end
         end
         c_ERR1:   w_state_nxt = c_ERR2;
         default:  w_state_nxt = c_IDLE;
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state  <= c_IDLE;
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_pwdata <= '0;
         r_hrdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_paddr  <= bus.HADDR;
            r_pwrite <= bus.HWRITE;
         end
         // Write data arrives in the AHB data phase, one cycle after the address
         if (r_state == c_WDATA) begin
            r_pwdata <= bus.HWDATA;
         end
         if (w_done && !r_pwrite) begin
            r_hrdata <= bus.PRDATA;
         end
      end
   end

   assign bus.PSEL      = (r_state == c_SETUP) || (r_state == c_ACCESS);
   assign bus.PENABLE   = (r_state == c_ACCESS);
   assign bus.PWRITE    = r_pwrite;
   assign bus.PADDR     = r_paddr;
   assign bus.PWDATA    = r_pwdata;
   assign bus.HREADYOUT = w_ready_state;
   assign bus.HRESP     = (r_state == c_ERR1) || (r_state == c_ERR2);
   assign bus.HRDATA    = r_hrdata;
endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_bridge.sv
`default_nettype none
// ============================================================================
// tb_ahb_apb_bridge : transaction-level self-checking bench for ahb_apb_bridge
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ahb_apb_bridge;
   localparam int ADDR_WIDTH = 16;

   typedef struct {
      logic        write;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          nwait;
      logic        err;
      int          idle_after;
   } xfer_t;

   logic HCLK = 1'b0;
   logic HRESET;
   always #5 HCLK = ~HCLK;

   ahb_apb_bridge_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();
   ahb_apb_bridge #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_hrdata = 32'h0;
   logic [31:0] m_pwdata = 32'h0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic apb_junk();
      bus.PREADY  = 1'($urandom);
      bus.PSLVERR = 1'($urandom);
      bus.PRDATA  = $urandom;
   endtask

   // Wait-state cycles: HREADY low, so everything else on AHB is noise
   task automatic ahb_junk();
      bus.HREADY = 1'b0;
      bus.HSEL   = 1'($urandom);
      bus.HTRANS = 2'($urandom);
      bus.HADDR  = 16'($urandom);
      bus.HWRITE = 1'($urandom);
      bus.HPROT  = 4'($urandom);
   endtask

   task automatic ahb_idle_cycle();
      bus.HREADY = 1'b1;
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'($urandom_range(0, 1));
      bus.HADDR  = 16'($urandom);
      bus.HWRITE = 1'($urandom);
      bus.HWDATA = $urandom;
      apb_junk();
      step();
      check_val("idle_hreadyout", 32'(bus.HREADYOUT), 32'd1);
      check_val("idle_hresp", 32'(bus.HRESP), 32'd0);
      check_val("idle_psel", 32'(bus.PSEL), 32'd0);
   endtask

   // Called in a cycle where the bridge is expected ready; returns in the
   // completing (HREADYOUT=1) cycle so the next transfer can be pipelined.
   task automatic run_xfer(input xfer_t t);
      int k = 0, acc = 0, setups = 0, setup_k = 0, en = 0, err1 = 0;
      logic done = 1'b0, stable = 1'b1;
      logic [31:0] s_paddr = 0, s_pwrite = 0, s_pwdata = 0;
      logic [31:0] exp_pw = t.write ? t.wdata : m_pwdata;
      int exp_lat = (t.write ? 4 : 3) + t.nwait + (t.err ? 1 : 0);

      bus.HREADY = 1'b1;
      bus.HSEL   = 1'b1;
      bus.HTRANS = {1'b1, 1'($urandom)};
      bus.HADDR  = t.addr;
      bus.HWRITE = t.write;
      bus.HSIZE  = 3'd2;
      bus.HPROT  = 4'($urandom);
      bus.HWDATA = $urandom;
      apb_junk();
      while (!done && k < 40) begin
         step();
         k++;
         done = bus.HREADYOUT;
         if (bus.PSEL && !bus.PENABLE) begin
            setups++;
            setup_k  = k;
            s_paddr  = 32'(bus.PADDR);
            s_pwrite = 32'(bus.PWRITE);
            s_pwdata = bus.PWDATA;
         end
         if (bus.PSEL && bus.PENABLE) en++;
         if (bus.PSEL && (bus.PADDR !== t.addr || bus.PWRITE !== t.write || bus.PWDATA !== exp_pw))
            stable = 1'b0;
         if (!done && bus.HRESP) err1++;
         if (!done) begin
            ahb_junk();
            bus.HWDATA = (k == 1) ? t.wdata : $urandom;
            if (bus.PSEL && bus.PENABLE) begin
               bus.PREADY  = (acc == t.nwait);
               bus.PSLVERR = (acc == t.nwait) ? t.err : 1'($urandom);
               bus.PRDATA  = (acc == t.nwait) ? t.rdata : $urandom;
               acc++;
            end else begin
               apb_junk();
            end
         end
      end
      if (!t.write) m_hrdata = t.rdata;
      if (t.write) m_pwdata = t.wdata;
      check_val("latency", 32'(k), 32'(exp_lat));
      check_val("hresp", 32'(bus.HRESP), 32'(t.err));
      check_val("err1_cycles", 32'(err1), 32'(t.err));
      check_val("hrdata", bus.HRDATA, m_hrdata);
      check_val("setups", 32'(setups), 32'd1);
      check_val("setup_cycle", 32'(setup_k), t.write ? 32'd2 : 32'd1);
      check_val("penable_cycles", 32'(en), 32'(t.nwait + 1));
      check_val("paddr", s_paddr, 32'(t.addr));
      check_val("pwrite", s_pwrite, 32'(t.write));
      check_val("pwdata", s_pwdata, exp_pw);
      check_val("apb_stable", 32'(stable), 32'd1);
      for (int i = 0; i < t.idle_after; i++) ahb_idle_cycle();
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_psel"}, 32'(bus.PSEL), 32'd0);
      check_val({tag, "_penable"}, 32'(bus.PENABLE), 32'd0);
      check_val({tag, "_pwrite"}, 32'(bus.PWRITE), 32'd0);
      check_val({tag, "_paddr"}, 32'(bus.PADDR), 32'd0);
      check_val({tag, "_pwdata"}, bus.PWDATA, 32'd0);
      check_val({tag, "_hrdata"}, bus.HRDATA, 32'd0);
      check_val({tag, "_hreadyout"}, 32'(bus.HREADYOUT), 32'd1);
      check_val({tag, "_hresp"}, 32'(bus.HRESP), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      xfer_t t;
      xfer_t dir[6];
      int k;

      HRESET     = 1'b1;
      bus.HSEL   = 1'b0;
      bus.HADDR  = '0;
      bus.HTRANS = 2'd0;
      bus.HWRITE = 1'b0;
      bus.HSIZE  = 3'd2;
      bus.HPROT  = 4'd0;
      bus.HREADY = 1'b1;
      bus.HWDATA = '0;
      apb_junk();
      step();
      step();
      check_reset_state("reset");
      HRESET = 1'b0;

      dir[0] = '{1'b0, 16'h0010, 32'h0,         32'hA5A5_0001, 0, 1'b0, 1};
      dir[1] = '{1'b1, 16'h0024, 32'hDEAD_BEEF, 32'h0,         0, 1'b0, 0};
      dir[2] = '{1'b0, 16'h0030, 32'h0,         32'h1234_5678, 3, 1'b0, 0};
      dir[3] = '{1'b1, 16'h0038, 32'h0BAD_F00D, 32'h0,         0, 1'b1, 1};
      dir[4] = '{1'b1, 16'h0000, 32'h5555_AAAA, 32'h0,         0, 1'b0, 0};
      dir[5] = '{1'b0, 16'h0004, 32'h0,         32'hCAFE_0004, 1, 1'b0, 2};
      foreach (dir[i]) run_xfer(dir[i]);

      for (int n = 0; n < 60; n++) begin
         t.write      = 1'($urandom);
         t.addr       = 16'($urandom);
         t.wdata      = $urandom;
         t.rdata      = $urandom;
         t.nwait      = $urandom_range(0, 4);
         t.err        = ($urandom_range(0, 4) == 0);
         t.idle_after = $urandom_range(0, 2);
         run_xfer(t);
      end

      // Reset while an ACCESS is stalled by PREADY=0
      bus.HREADY = 1'b1;
      bus.HSEL   = 1'b1;
      bus.HTRANS = 2'b10;
      bus.HADDR  = 16'h0040;
      bus.HWRITE = 1'b0;
      k = 0;
      do begin
         step();
         k++;
         ahb_junk();
         bus.PREADY = 1'b0;
      end while (!(bus.PSEL && bus.PENABLE) && k < 10);
      check_val("rst_reach_access", 32'(bus.PENABLE), 32'd1);
      HRESET = 1'b1;
      step();
      HRESET     = 1'b0;
      bus.HREADY = 1'b1;
      bus.HSEL   = 1'b0;
      check_reset_state("midrst");
      m_hrdata = 32'h0;
      m_pwdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         apb_junk();
         step();
         check_val("midrst_no_psel", 32'(bus.PSEL), 32'd0);
      end
      t = '{1'b0, 16'h0044, 32'h0, 32'h600D_0044, 1, 1'b0, 1};
      run_xfer(t);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
